neopix_tx: RTL and testbench

Downstream consumer of the SPI receive stage: accepts the byte stream it strobes out (3 bytes per pixel, GRB, MSB first) into a small FIFO and serialises it onto a single WS2812 data line. The block generates the high/low bit waveform and the latch (reset) gap. The output pin drives the LED strip directly.

---
 rtl/neopix_pkg.sv | 29 ++
 rtl/neopix_fifo.sv | 47 ++++
 rtl/neopix_tx.sv | 176 +++++++++++++++++
 tb/tb_neopix_tx.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/neopix_pkg.sv
// Shared types, default 50 MHz timing constants and helpers for the WS2812 transmitter.
package neopix_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_LATCH = 3'd4
  } state_e;

  // 50 MHz clock: 400 ns / 800 ns high times, 1.26 us bit, 60 us latch gap.
  localparam int unsigned DEF_T0H_CYC    = 20;
  localparam int unsigned DEF_T1H_CYC    = 40;
  localparam int unsigned DEF_BIT_CYC    = 63;
  localparam int unsigned DEF_LATCH_CYC  = 3000;
  localparam int unsigned DEF_FIFO_DEPTH = 16;

  // Number of bits needed to hold values 0 .. v-1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/neopix_fifo.sv
// Byte FIFO between the SPI receive stage and the serialiser; head is readable combinationally.
module neopix_fifo
  import neopix_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       wr_en_i,
  input  logic [7:0] wr_data_i,
  input  logic       rd_en_i,
  output logic [7:0] rd_data_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic [7:0]  mem_q [DEPTH];

  assign wptr_d    = wptr_q + PW'(wr_en_i);
  assign rptr_d    = rptr_q + PW'(rd_en_i);
  assign rd_data_o = mem_q[rptr_q[AW-1:0]];
  assign empty_o   = (wptr_q == rptr_q);
  assign full_o    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage array, no reset needed since the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/neopix_tx.sv
// WS2812 serialiser: buffers GRB bytes and drives the high/low bit waveform plus latch gap.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | line low, waiting for a byte in the FIFO
// LOAD     | pop head byte into the shift register (one low cycle)
// HIGH     | line high for T1H_CYC or T0H_CYC depending on shreg[7]
// LOW      | line low for the rest of the bit period
// LATCH    | line low for LATCH_CYC, then frame_done pulse
module neopix_tx
  import neopix_pkg::*;
#(
  parameter int unsigned T0H_CYC    = DEF_T0H_CYC,
  parameter int unsigned T1H_CYC    = DEF_T1H_CYC,
  parameter int unsigned BIT_CYC    = DEF_BIT_CYC,
  parameter int unsigned LATCH_CYC  = DEF_LATCH_CYC,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       dout_o,
  output logic       busy_o,
  output logic       frame_done_o,
  output logic       overflow_o
);

  localparam int unsigned PH_MAX = (BIT_CYC > LATCH_CYC) ? BIT_CYC : LATCH_CYC;
  localparam int unsigned PH_W   = clog2(PH_MAX);

  // LOAD borrows the final low cycle of the previous bit, so a low phase needs at least 2 cycles.
  localparam bit PARAMS_OK = (T0H_CYC >= 1) && (T0H_CYC < T1H_CYC) && (T1H_CYC + 2 <= BIT_CYC) &&
                             (LATCH_CYC >= 1) && (FIFO_DEPTH >= 2) &&
                             ((FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0);

  if (!PARAMS_OK) begin : g_param_check
    $fatal(1, "neopix_tx: illegal timing or FIFO depth parameters");
  end

  localparam logic [PH_W-1:0] T0H_LAST   = PH_W'(T0H_CYC - 1);
  localparam logic [PH_W-1:0] T1H_LAST   = PH_W'(T1H_CYC - 1);
  localparam logic [PH_W-1:0] LO0_LAST   = PH_W'(BIT_CYC - T0H_CYC - 1);
  localparam logic [PH_W-1:0] LO1_LAST   = PH_W'(BIT_CYC - T1H_CYC - 1);
  localparam logic [PH_W-1:0] LO0_EARLY  = PH_W'(BIT_CYC - T0H_CYC - 2);
  localparam logic [PH_W-1:0] LO1_EARLY  = PH_W'(BIT_CYC - T1H_CYC - 2);
  localparam logic [PH_W-1:0] LATCH_LAST = PH_W'(LATCH_CYC - 1);

  state_e          state_q, state_d;
  logic [PH_W-1:0] ph_q, ph_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            dout_q;
  logic            frame_done_q, frame_done_d;
  logic            ovf_q, ovf_d;

  logic            pop;
  logic            fifo_wr;
  logic            fifo_full;
  logic            fifo_empty;
  logic [7:0]      fifo_head;

  logic [PH_W-1:0] hi_last;
  logic [PH_W-1:0] lo_last;
  logic [PH_W-1:0] lo_early;

  // A pop in the same cycle frees a slot, so a write while full is still accepted then.
  assign fifo_wr = valid_i && (!fifo_full || pop);
  assign ovf_d   = ovf_q || (valid_i && fifo_full && !pop);

  assign hi_last  = shreg_q[7] ? T1H_LAST  : T0H_LAST;
  assign lo_last  = shreg_q[7] ? LO1_LAST  : LO0_LAST;
  assign lo_early = shreg_q[7] ? LO1_EARLY : LO0_EARLY;

  neopix_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .wr_en_i  (fifo_wr),
    .wr_data_i(data_i),
    .rd_en_i  (pop),
    .rd_data_o(fifo_head),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  // Next-state logic for the bit sequencer, phase/bit counters and shift register.
  always_comb begin
    state_d      = state_q;
    ph_d         = ph_q;
    bit_d        = bit_q;
    shreg_d      = shreg_q;
    pop          = 1'b0;
    frame_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        pop     = 1'b1;
        shreg_d = fifo_head;
        bit_d   = 3'd7;
        ph_d    = '0;
        state_d = ST_HIGH;
      end
      ST_HIGH: begin
        if (ph_q == hi_last) begin
          ph_d    = '0;
          state_d = ST_LOW;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      ST_LOW: begin
        // Back-to-back bytes: leave one cycle early so LOAD fills the last low cycle.
        // Reaching lo_last on the final bit means the FIFO was empty a cycle ago.
        if ((bit_q == 3'd0) && !fifo_empty && (ph_q == lo_early)) begin
          ph_d    = '0;
          state_d = ST_LOAD;
        end else if (ph_q == lo_last) begin
          ph_d = '0;
          if (bit_q != 3'd0) begin
            shreg_d = {shreg_q[6:0], 1'b0};
            bit_d   = bit_q - 3'd1;
            state_d = ST_HIGH;
          end else begin
            state_d = ST_LATCH;
          end
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      ST_LATCH: begin
        if (ph_q == LATCH_LAST) begin
          ph_d         = '0;
          frame_done_d = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        ph_d    = '0;
      end
    endcase
  end

  // State and datapath registers; the data line is registered from the next state.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= ST_IDLE;
      ph_q         <= '0;
      bit_q        <= '0;
      shreg_q      <= '0;
      dout_q       <= 1'b0;
      frame_done_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ph_q         <= ph_d;
      bit_q        <= bit_d;
      shreg_q      <= shreg_d;
      dout_q       <= (state_d == ST_HIGH);
      frame_done_q <= frame_done_d;
      ovf_q        <= ovf_d;
    end
  end

  assign dout_o       = dout_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign frame_done_o = frame_done_q;
  assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_neopix_tx.sv
// Self-checking bench for neopix_tx: waveform decoder feeds a byte scoreboard.
module tb_neopix_tx;

  localparam int T0H   = 20;
  localparam int T1H   = 40;
  localparam int BIT   = 63;
  localparam int LATCH = 3000;
  localparam int DEPTH = 16;
  localparam int BYTE_CYC = 8 * BIT;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       valid = 1'b0;
  logic [7:0] data  = 8'h00;
  logic       dout, busy, fdone, ovf;

  neopix_tx #(
    .T0H_CYC   (T0H),
    .T1H_CYC   (T1H),
    .BIT_CYC   (BIT),
    .LATCH_CYC (LATCH),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i       (clk),
    .reset_ni    (rst_n),
    .data_i      (data),
    .valid_i     (valid),
    .dout_o      (dout),
    .busy_o      (busy),
    .frame_done_o(fdone),
    .overflow_o  (ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int errs  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    if (obs !== expv) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  logic [7:0] sb_q[$];

  // Waveform decoder state
  logic       prev_d = 1'b0;
  int         hi = 0, lo = 0, last_hi = 0, last_rise = 0;
  int         bits = 0, frames = 0, rises = 0, bytes_rx = 0, fd_cyc = 0;
  bit         in_frame = 1'b0;
  logic [7:0] sh = 8'h00;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_d   = 1'b0;
      hi       = 0;
      lo       = 0;
      bits     = 0;
      in_frame = 1'b0;
    end else begin
      if (dout && !prev_d) begin
        rises++;
        if (in_frame) chk("bit_period", cyc - last_rise, BIT);
        last_rise = cyc;
        in_frame  = 1'b1;
        hi        = 1;
      end else if (dout) begin
        hi++;
      end else if (prev_d) begin
        logic b;
        b = (hi > (T0H + T1H) / 2);
        chk("high_len", hi, b ? T1H : T0H);
        last_hi = hi;
        sh      = {sh[6:0], b};
        bits++;
        lo = 1;
        if (bits == 8) begin
          bits = 0;
          bytes_rx++;
          if (sb_q.size() == 0) chk("sb_extra_byte", 0, 1);
          else chk("byte", sh, sb_q.pop_front());
        end
      end else begin
        lo++;
      end
      if (fdone) begin
        frames++;
        fd_cyc = cyc;
        chk("latch_gap", lo - 1, BIT - last_hi + LATCH);
        chk("done_byte_align", bits, 0);
        chk("busy_at_done", busy, 0);
        in_frame = 1'b0;
      end
      prev_d = dout;
    end
  end

  int last_wr_cyc = 0;

  // Called at posedge+1; the byte is sampled on the following edge.
  task automatic send(input logic [7:0] b, input bit accept);
    data  = b;
    valid = 1'b1;
    @(posedge clk);
    #1;
    valid       = 1'b0;
    last_wr_cyc = cyc;
    if (accept) sb_q.push_back(b);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_frames(input int target, input int budget);
    int k;
    k = 0;
    while (frames < target && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("frame_count", frames, target);
  endtask

  task automatic apply_reset();
    #2;
    rst_n = 1'b0;
    sb_q.delete();
    idle_cycles(3);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    rst_n = 1'b0;
    idle_cycles(3);
    chk("rst_dout", dout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fdone", fdone, 0);
    chk("rst_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single byte 0x80: latency, busy timing, one frame.
    send(8'h80, 1'b1);
    chk("busy_before_load", busy, 0);
    idle_cycles(1);
    chk("busy_in_load", busy, 1);
    chk("dout_in_load", dout, 0);
    idle_cycles(1);
    chk("first_rise_n2", dout, 1);
    chk("first_rise_cyc", last_wr_cyc + 2, cyc);
    wait_frames(1, BYTE_CYC + LATCH + 100);
    chk("t1_bytes", bytes_rx, 1);
    chk("t1_busy_after", busy, 0);
    chk("t1_ovf", ovf, 0);

    // Three bytes two cycles apart: contiguous bits, single latch.
    send(8'hFF, 1'b1);
    idle_cycles(1);
    send(8'h00, 1'b1);
    idle_cycles(1);
    send(8'hA5, 1'b1);
    wait_frames(2, 3 * BYTE_CYC + LATCH + 200);
    chk("t2_bytes", bytes_rx, 4);
    chk("t2_sb_empty", sb_q.size(), 0);

    // Byte arriving during LATCH is sent right after frame_done.
    send(8'h3C, 1'b1);
    idle_cycles(BYTE_CYC + 100);
    chk("t3_in_latch_busy", busy, 1);
    send(8'hC3, 1'b1);
    wait_frames(3, LATCH + 100);
    begin
      int r0, k;
      r0 = rises;
      k  = 0;
      while (rises == r0 && k < 10) begin
        @(posedge clk);
        #1;
        k++;
      end
      chk("t3_rise_after_done", last_rise - fd_cyc, 2);
    end
    wait_frames(4, BYTE_CYC + LATCH + 100);
    chk("t3_bytes", bytes_rx, 6);

    // 20 back-to-back strobes: 17 accepted, overflow sticky until reset.
    for (int i = 0; i < 20; i++) send(8'h10 + 8'(i), i < 17);
    chk("t4_ovf_set", ovf, 1);
    wait_frames(5, 17 * BYTE_CYC + LATCH + 500);
    chk("t4_bytes", bytes_rx, 6 + 17);
    chk("t4_ovf_sticky", ovf, 1);
    apply_reset();
    chk("t4_ovf_cleared", ovf, 0);

    // Fill the FIFO, then write in exactly the pop cycle of the second byte.
    begin
      int n0;
      send(8'h40, 1'b1);
      n0 = last_wr_cyc;
      for (int i = 1; i < 17; i++) send(8'h40 + 8'(i), 1'b1);
      chk("t5_ovf_filled", ovf, 0);
      while (cyc < n0 + BYTE_CYC + 1) begin
        @(posedge clk);
        #1;
      end
      send(8'hEE, 1'b1);
      chk("t5_write_edge", last_wr_cyc, n0 + BYTE_CYC + 2);
      chk("t5_ovf_pop_write", ovf, 0);
    end
    wait_frames(6, 18 * BYTE_CYC + LATCH + 500);
    chk("t5_bytes", bytes_rx, 23 + 18);
    chk("t5_sb_empty", sb_q.size(), 0);

    // Reset during HIGH: line drops at once, buffered data discarded.
    send(8'hFF, 1'b0);
    send(8'hFF, 1'b0);
    send(8'hFF, 1'b0);
    begin
      int k;
      k = 0;
      while (!dout && k < 20) begin
        @(posedge clk);
        #1;
        k++;
      end
      chk("t6_started", dout, 1);
    end
    idle_cycles(10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_dout", dout, 0);
    chk("t6_async_busy", busy, 0);
    sb_q.delete();
    idle_cycles(2);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    begin
      int r0;
      r0 = rises;
      idle_cycles(1500);
      chk("t6_no_tx_after_reset", rises, r0);
      chk("t6_idle_busy", busy, 0);
    end
    send(8'h5A, 1'b1);
    wait_frames(7, BYTE_CYC + LATCH + 100);
    chk("t6_sb_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, errs + 1);
    $fatal(1, "watchdog");
  end

endmodule
